// File: rtl/id_stage_pipe.sv
// Registered RV32I/RV64I decode stage: field extraction, immediate generation,
// register-file read addressing, load-use bubble insertion and the ID/EX register.
module id_stage_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    // Decoded fields of the instruction presented by IF
    logic [6:0]       dec_opcode;
    logic [4:0]       dec_rd_raw;
    logic [4:0]       dec_rd;
    logic [2:0]       dec_funct3;
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic [6:0]       dec_funct7;
    logic [31:0]      dec_imm32;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_legal;
    logic             dec_illegal;
    logic             uses_rs1;
    logic             uses_rs2;

    // Control terms
    logic             advance;
    logic             load_use;
    logic             load_en;

    // ID/EX register state
    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
    logic [4:0]       ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [6:0]       ex_opcode_q, ex_funct7_q;
    logic [2:0]       ex_funct3_q;
    logic             ex_illegal_q;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    assign dec_opcode  = if_instr[6:0];
    assign dec_rd_raw  = if_instr[11:7];
    assign dec_funct3  = if_instr[14:12];
    assign dec_rs1     = if_instr[19:15];
    assign dec_rs2     = if_instr[24:20];
    assign dec_funct7  = if_instr[31:25];

    assign rf_rs1_addr = dec_rs1;
    assign rf_rs2_addr = dec_rs2;

    // Opcode classification and 32-bit immediate assembly
    always_comb begin
        dec_imm32 = 32'd0;
        dec_legal = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        dec_rd    = dec_rd_raw;
        unique case (dec_opcode)
            OpLoad, OpImm, OpJalr, OpSystem: begin
                dec_imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OpStore: begin
                dec_imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                uses_rs2  = 1'b1;
                dec_rd    = 5'd0;
            end
            OpBranch: begin
                dec_imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                             if_instr[30:25], if_instr[11:8], 1'b0};
                uses_rs2  = 1'b1;
                dec_rd    = 5'd0;
            end
            OpLui, OpAuipc: begin
                dec_imm32 = {if_instr[31:12], 12'd0};
                uses_rs1  = 1'b0;
            end
            OpJal: begin
                dec_imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                             if_instr[20], if_instr[30:21], 1'b0};
                uses_rs1  = 1'b0;
            end
            OpReg: begin
                uses_rs2 = 1'b1;
            end
            OpMisc: begin
                dec_imm32 = 32'd0;
            end
            default: begin
                dec_legal = 1'b0;
                uses_rs1  = 1'b0;
            end
        endcase
    end

    // Every legal opcode ends in 2'b11, so the explicit low-bit test is belt and braces
    assign dec_illegal = ~dec_legal | (if_instr[1:0] != 2'b11);
    assign dec_imm     = XLEN'($signed(dec_imm32));

    // Handshake and hazard terms
    always_comb begin
        advance  = ~ex_valid_q | ex_ready;
        load_use = ex_valid_q & (ex_opcode_q == OpLoad) & (ex_rd_q != 5'd0) &
                   ((uses_rs1 & (dec_rs1 == ex_rd_q)) | (uses_rs2 & (dec_rs2 == ex_rd_q)));
        id_ready = flush | (advance & ~load_use);
        load_en  = ~flush & advance & ~load_use & if_valid;
    end

    // Next valid and saturating bubble counter
    always_comb begin
        ex_valid_d    = ex_valid_q;
        stall_count_d = stall_count_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (advance & load_use) begin
            ex_valid_d = 1'b0;
            if (if_valid && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end else if (advance) begin
            ex_valid_d = if_valid;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Payload captures only on a real issue so it stays frozen across holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_opcode_q   <= '0;
            ex_funct3_q   <= '0;
            ex_funct7_q   <= '0;
            ex_illegal_q  <= 1'b0;
        end else if (load_en) begin
            ex_pc_q       <= if_pc;
            ex_rs1_data_q <= rf_rs1_data;
            ex_rs2_data_q <= rf_rs2_data;
            ex_imm_q      <= dec_imm;
            ex_rs1_q      <= dec_rs1;
            ex_rs2_q      <= dec_rs2;
            ex_rd_q       <= dec_rd;
            ex_opcode_q   <= dec_opcode;
            ex_funct3_q   <= dec_funct3;
            ex_funct7_q   <= dec_funct7;
            ex_illegal_q  <= dec_illegal;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_opcode   = ex_opcode_q;
    assign ex_funct3   = ex_funct3_q;
    assign ex_funct7   = ex_funct7_q;
    assign ex_illegal  = ex_illegal_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized bench for id_stage_pipe (XLEN=64, narrow stall counter to reach saturation).
module tb_id_stage_pipe;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 4;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             id_ready;
    logic [4:0]       rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
    logic             flush;
    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [6:0]       ex_opcode, ex_funct7;
    logic [2:0]       ex_funct3;
    logic             ex_illegal;
    logic [CNT_W-1:0] stall_count;

    id_stage_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .flush(flush),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_illegal(ex_illegal),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the ID/EX contents
    typedef struct {
        bit          valid;
        bit [63:0]   pc, d1, d2, imm;
        bit [4:0]    rs1, rs2, rd;
        bit [6:0]    op, f7;
        bit [2:0]    f3;
        bit          ill;
    } ex_t;

    ex_t m;
    int  m_stall;

    function automatic bit is_legal(input bit [6:0] op);
        return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                          7'h0F, 7'h73};
    endfunction

    // Immediate computed arithmetically from the sign-extended word
    function automatic bit [63:0] ref_imm(input bit [31:0] w);
        longint s;
        longint u;
        s = longint'($signed(w));
        u = longint'({32'd0, w});
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return s >>> 20;
            7'h23: return ((s >>> 25) << 5) | ((u >> 7) & 31);
            7'h63: return ((s >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                          (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
            7'h37, 7'h17: return (s >>> 12) << 12;
            7'h6F: return ((s >>> 31) << 20) | (((u >> 12) & 255) << 12) |
                          (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit reads_rs1(input bit [6:0] op);
        return is_legal(op) && !(op inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic bit reads_rs2(input bit [6:0] op);
        return op inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic void model_reset();
        m = '{default: 0};
        m_stall = 0;
    endfunction

    // One clock: drive at negedge, check combinational outputs, step model, check registers
    task automatic cycle(input bit v, input bit [31:0] w, input bit fl, input bit er);
        bit adv, lu;
        bit [6:0] op;
        @(negedge clk);
        if_valid    = v;
        if_instr    = w;
        if_pc       = {$urandom, $urandom};
        rf_rs1_data = {$urandom, $urandom};
        rf_rs2_data = {$urandom, $urandom};
        flush       = fl;
        ex_ready    = er;
        #1;
        op  = w[6:0];
        adv = !m.valid || er;
        lu  = m.valid && (m.op == 7'h03) && (m.rd != 0) &&
              ((reads_rs1(op) && w[19:15] == m.rd) || (reads_rs2(op) && w[24:20] == m.rd));
        check_eq("id_ready", {63'd0, id_ready}, {63'd0, fl || (adv && !lu)});
        check_eq("rs1_addr", {59'd0, rf_rs1_addr}, {59'd0, w[19:15]});
        check_eq("rs2_addr", {59'd0, rf_rs2_addr}, {59'd0, w[24:20]});
        if (fl) begin
            m.valid = 0;
        end else if (adv && lu) begin
            m.valid = 0;
            if (v && m_stall < SAT) m_stall++;
        end else if (adv) begin
            m.valid = v;
            if (v) begin
                m.pc  = if_pc;
                m.d1  = rf_rs1_data;
                m.d2  = rf_rs2_data;
                m.imm = ref_imm(w);
                m.rs1 = w[19:15];
                m.rs2 = w[24:20];
                m.rd  = (op == 7'h23 || op == 7'h63) ? 5'd0 : w[11:7];
                m.op  = op;
                m.f3  = w[14:12];
                m.f7  = w[31:25];
                m.ill = !is_legal(op) || (w[1:0] != 2'b11);
            end
        end
        @(posedge clk);
        #1;
        check_eq("ex_valid", {63'd0, ex_valid}, {63'd0, m.valid});
        check_eq("stall_count", {60'd0, stall_count}, 64'(m_stall));
        if (m.valid) begin
            check_eq("ex_pc", ex_pc, m.pc);
            check_eq("ex_rs1_data", ex_rs1_data, m.d1);
            check_eq("ex_rs2_data", ex_rs2_data, m.d2);
            check_eq("ex_imm", ex_imm, m.imm);
            check_eq("ex_regs", {49'd0, ex_rs1, ex_rs2, ex_rd}, {49'd0, m.rs1, m.rs2, m.rd});
            check_eq("ex_ops", {47'd0, ex_opcode, ex_funct3, ex_funct7},
                     {47'd0, m.op, m.f3, m.f7});
            check_eq("ex_illegal", {63'd0, ex_illegal}, {63'd0, m.ill});
        end
    endtask

    function automatic bit [31:0] rand_instr();
        bit [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                               7'h33, 7'h0F, 7'h73};
        bit [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) == 0) return w;
        w[6:0]   = ops[$urandom_range(0, 10)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    localparam bit [31:0] LW_X5  = 32'h0000A283;
    localparam bit [31:0] LW_X0  = 32'h0000A003;
    localparam bit [31:0] ADD_D  = 32'h00728333;
    localparam bit [31:0] LUI_X5 = 32'h000002B7;
    localparam bit [31:0] ADDI   = 32'hFFF00093;

    int vcount;
    int saved_stall;

    initial begin
        model_reset();
        rst = 1'b1;
        if_valid = 0; if_instr = 0; if_pc = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        flush = 0; ex_ready = 1;
        #12;
        check_eq("rst_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("rst_stall", {60'd0, stall_count}, 64'd0);
        check_eq("rst_imm", ex_imm, 64'd0);
        check_eq("rst_pc", ex_pc, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Immediates at XLEN=64
        cycle(1, ADDI, 0, 1);
        check_eq("imm_addi", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1, 32'h80000137, 0, 1);
        check_eq("imm_lui", ex_imm, 64'hFFFF_FFFF_8000_0000);
        cycle(1, 32'hFE000EE3, 0, 1);
        check_eq("imm_beq", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("beq_rd", {59'd0, ex_rd}, 64'd0);

        // Load-use produces exactly one bubble
        saved_stall = m_stall;
        cycle(1, LW_X5, 0, 1);
        cycle(1, ADD_D, 0, 1);
        check_eq("lu_bubble", {63'd0, ex_valid}, 64'd0);
        check_eq("lu_stall", {60'd0, stall_count}, 64'(saved_stall + 1));
        cycle(1, ADD_D, 0, 1);
        check_eq("lu_issue", {57'd0, ex_opcode}, 64'h33);
        // No bubble for LUI or load to x0
        cycle(1, LW_X5, 0, 1);
        cycle(1, LUI_X5, 0, 1);
        check_eq("lui_nobubble", {63'd0, ex_valid}, 64'd1);
        cycle(1, LW_X0, 0, 1);
        cycle(1, 32'h00000333, 0, 1);
        check_eq("x0_nobubble", {63'd0, ex_valid}, 64'd1);

        // Back-pressure for three cycles, then release
        cycle(1, ADDI, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, ADD_D, 0, 0);
        check_eq("bp_valid", {63'd0, ex_valid}, 64'd1);
        check_eq("bp_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1, ADD_D, 0, 1);
        check_eq("bp_release", {57'd0, ex_opcode}, 64'h33);

        // Flush with back-pressure and a pending load-use
        cycle(1, LW_X5, 0, 1);
        saved_stall = m_stall;
        cycle(1, ADD_D, 1, 0);
        check_eq("flush_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("flush_stall", {60'd0, stall_count}, 64'(saved_stall));

        // Illegal words flow with zero immediate
        cycle(1, 32'h00000000, 0, 1);
        check_eq("ill0", {62'd0, ex_valid, ex_illegal}, 64'd3);
        check_eq("ill0_imm", ex_imm, 64'd0);
        cycle(1, 32'hFFFFFFFF, 0, 1);
        check_eq("ill1", {62'd0, ex_valid, ex_illegal}, 64'd3);
        check_eq("ill1_imm", ex_imm, 64'd0);

        // 100 back-to-back independent instructions
        vcount = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1, {12'($urandom), 5'd0, 3'd0, 5'((i % 31) + 1), 7'h13}, 0, 1);
            if (ex_valid) vcount++;
        end
        check_eq("stream", 64'(vcount), 64'd100);

        // Drive the stall counter into saturation
        for (int i = 0; i < SAT + 4; i++) begin
            cycle(1, LW_X5, 0, 1);
            cycle(1, ADD_D, 0, 1);
        end
        check_eq("stall_sat", {60'd0, stall_count}, 64'(SAT));

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) != 0, rand_instr(), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset while ex_valid=1
        cycle(1, ADDI, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("arst_stall", {60'd0, stall_count}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, LUI_X5, 0, 1);
        check_eq("post_rst_issue", {63'd0, ex_valid}, 64'd1);
        for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 9) != 0, rand_instr(), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, registered decode stage: RV32I/RV64I field extraction, immediate generation, register-file read addressing, and an ID/EX pipeline register.
- Adds what the combinational decoder lacks: valid/ready handshake with IF and EX, load-use hazard detection with bubble insertion, flush, illegal-opcode flagging and a saturating stall counter.
- Sits between the IF stage and the EX stage. The register file is read combinationally in the same cycle.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64. Immediates, PC and operand data are XLEN wide.
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- if_valid  input  1  IF presents a valid instruction
- if_instr  input  32  instruction word
- if_pc  input  XLEN  PC of if_instr
- id_ready  output  1  ID accepts if_instr this cycle
- rf_rs1_addr  output  5  = if_instr[19:15], combinational
- rf_rs2_addr  output  5  = if_instr[24:20], combinational
- rf_rs1_data  input  XLEN  register-file read data for rs1, same cycle
- rf_rs2_data  input  XLEN  register-file read data for rs2, same cycle
- flush  input  1  kill the instruction in ID and in the ID/EX register (taken branch or jump)
- ex_ready  input  1  EX accepts the ID/EX contents this cycle
- ex_valid  output  1  ID/EX register holds a valid instruction
- ex_pc  output  XLEN  registered PC
- ex_rs1_data  output  XLEN  registered rs1 operand
- ex_rs2_data  output  XLEN  registered rs2 operand
- ex_imm  output  XLEN  registered sign-extended immediate
- ex_rs1  output  5  registered rs1 index
- ex_rs2  output  5  registered rs2 index
- ex_rd  output  5  registered rd index; 0 for S/B types
- ex_opcode  output  7  registered opcode
- ex_funct3  output  3  registered funct3
- ex_funct7  output  7  registered funct7
- ex_illegal  output  1  registered illegal-instruction flag
- stall_count  output  CNT_W  number of load-use bubble cycles

Behaviour:
- Reset (async, active-high): ex_valid=0, stall_count=0, every other registered output=0. On release, resumes on the next rising edge.
- Field decode:
  - opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- Immediate formats (sign-extended from instr[31] to XLEN):
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011.
  - S: 0100011.
  - B: 1100011; bit0=0.
  - U: LUI 0110111, AUIPC 0010111; {instr[31:12],12'b0}, then sign-extended for XLEN=64.
  - J: 1101111; bit0=0.
  - Any other opcode: imm=0.
- Illegal: set when instr[1:0]!=2'b11, or opcode is outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP 0110011, MISC-MEM 0001111, SYSTEM}. An illegal instruction still flows down the pipe with ex_illegal=1.
- Register usage:
  - uses_rs1 is true for all legal opcodes except LUI, AUIPC and JAL.
  - uses_rs2 is true only for BRANCH, STORE and OP.
  - ex_rd is forced to 0 for STORE and BRANCH.
- Control terms:
  - advance = ~ex_valid | ex_ready.
  - load_use = ex_valid & (ex_opcode==LOAD) & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
  - id_ready = flush | (advance & ~load_use).
- Register update, in priority order:
  1. flush=1: ex_valid<=0. The IF instruction is consumed and discarded (id_ready=1). flush wins over load_use and over ex_ready=0.
  2. advance & load_use: ex_valid<=0 (one bubble). IF is held (id_ready=0). The next cycle the load has left EX and the instruction issues; the MEM-stage forwarding path covers the data.
  3. advance & ~load_use: ex_valid<=if_valid. When if_valid=1, all ex_* fields are loaded from the decode and from rf_*_data.
  4. ~advance: all ex_* registers hold.
- Payload registers capture only when a valid instruction is loaded. Their value is don't-care while ex_valid=0, but they must not toggle during a hold.
- Latency: one cycle from IF acceptance to ex_valid. Throughput is 1 instruction/cycle with no hazards.
- stall_count: increments by 1 on every cycle with advance & load_use & if_valid & ~flush. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Back-pressure: ex_ready=0 while ex_valid=1 gives advance=0 and id_ready=0; a flush still clears ex_valid.

Test Plan:
- Reset mid-stream: assert rst while ex_valid=1 -> ex_valid and stall_count read 0 immediately (async); the first instruction after release appears one cycle after acceptance.
- Immediates with XLEN=64: ADDI x1,x0,-1 (0xFFF00093) -> ex_imm=0xFFFFFFFFFFFFFFFF; LUI x2,0x80000 (0x80000137) -> ex_imm=0xFFFFFFFF80000000; BEQ offset -4 (0xFE000EE3) -> ex_imm=-4 and ex_rd=0.
- Load-use: LW x5,0(x1) then ADD x6,x5,x7 with ex_ready=1 -> exactly one cycle with ex_valid=0 and id_ready=0, stall_count=1, then ADD issues. The same sequence with LUI x5 in the second slot, or with rd=x0 in the load -> no bubble.
- Back-pressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* registers stable, id_ready=0, stall_count unchanged. On release, the held IF instruction issues next cycle.
- Flush: flush=1 while ex_valid=1, ex_ready=0 and a load-use is pending -> id_ready=1, ex_valid=0 next cycle, stall_count unchanged.
- Illegal: instr=0x00000000 and instr=0xFFFFFFFF -> ex_valid=1, ex_illegal=1, ex_imm=0. Streaming 100 legal back-to-back non-dependent instructions -> 100 ex_valid cycles with no gaps.
